filter_win_ctrl: RTL and testbench
==================================

# filter_win_ctrl

Sequencer for the 5x5 binary Gaussian window filter in the OV5640 pipeline. It tracks pixel column and row within a frame, drives the address and rotation controls for four external 1-bit line buffers, and asserts the filter enable only when a full 5x5 neighbourhood is available. It also produces a delayed output-valid strobe with window-centre coordinates.

## Interface
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- ADDR_W, 10, line-buffer address width; requires 2^ADDR_W >= IMG_W
- FILT_LAT, 2, filter latency in cycles from filt_en to filtered data valid; must be >= 1

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse, coincident with or before the first pixel of a frame
- pix_valid  in  1  current camera pixel is valid
- lb_addr  out  ADDR_W  line-buffer address
  - combinational, equals the column counter
  - applies to all four buffers
- lb_wr_en  out  4  one-hot write enable to the buffer selected by wr_ptr
  - equals pix_valid in ACTIVE, otherwise 0
- row_map  out  8  physical buffer index per logical row
  - [1:0] holds row r-1, [3:2] row r-2, [5:4] row r-3, [7:6] row r-4
- filt_en  out  1  registered; drives the filter en input
- out_valid  out  1  filt_en delayed by FILT_LAT cycles
- out_x  out  ADDR_W  window-centre column, aligned with out_valid
- out_y  out  ADDR_W  window-centre row, aligned with out_valid
- frame_done  out  1  one-cycle pulse after the last pixel of a frame
- drop_err  out  1  sticky flag: a pixel arrived outside ACTIVE

## Operation
States: IDLE, ACTIVE, DONE.
- IDLE → ACTIVE on frame_start. This clears col, row and wr_ptr, and clears drop_err.
- In ACTIVE, each pix_valid writes the pixel at lb_addr = col into the buffer selected by wr_ptr, then increments col.
- At the end of a line (col == IMG_W-1 with pix_valid):
  - col wraps to 0 and row increments.
  - wr_ptr increments mod 4.
- ACTIVE → DONE on the last pixel (col == IMG_W-1, row == IMG_H-1, pix_valid). frame_done pulses in the DONE cycle.
- DONE → IDLE unconditionally on the next cycle. If frame_start arrives in the DONE cycle, the next state is ACTIVE.
- A frame_start while in ACTIVE restarts the frame: counters and wr_ptr are cleared, and the pixel in the same cycle is treated as pixel (0,0).
- A pix_valid in IDLE or DONE is ignored: no write, no counter change. drop_err is set and held until the next frame_start.
- Line buffers are read-first RAMs. Row r-4 is therefore read from buffer wr_ptr before it is overwritten.
- Row mapping: row_map = {wr_ptr, wr_ptr+1, wr_ptr+2, wr_ptr+3} (mod 4, MSB field first). The r-1 field equals wr_ptr-1.
- Window condition: pix_valid && ACTIVE && row >= 4 && col >= 4.
- Window centre: x = col-2, y = row-2, both unsigned ADDR_W.
- No arithmetic wraps: counters saturate by construction through the line and frame wrap rules.

## Timing
- Reset values:
  - state IDLE; col, row, wr_ptr = 0
  - filt_en, out_valid, frame_done, drop_err = 0
  - out_x, out_y = 0
  - lb_wr_en = 0, because the combinational output is gated by the state
- lb_addr and lb_wr_en are combinational from registered counters and pix_valid, in the same cycle as the pixel.
- filt_en is registered one cycle after the qualifying pixel, which aligns it with read-first RAM output.
- out_valid, out_x and out_y lag filt_en by exactly FILT_LAT cycles through a shift pipeline. The pipeline is flushed only by rst, so windows in flight still emit after a frame restart.
- row_map is registered with wr_ptr and updates on the cycle after the end-of-line pixel.
- Throughput is one pixel per cycle. Gaps in pix_valid stall the counters and generate no filt_en.

## Test plan
1. IMG_W=8, IMG_H=6, FILT_LAT=2; frame_start then 48 back-to-back pixels.
   - First filt_en one cycle after pixel index 36.
   - 8 filt_en pulses in total.
   - First out_valid with out_x=2, out_y=2 two cycles later.
   - frame_done one cycle after pixel 47.
2. Same frame with pix_valid toggling every other cycle.
   - Identical write addresses and 8 filt_en pulses, each one cycle after its qualifying pixel.
3. Rotation check: row_map reads 8'b00_01_10_11 after reset.
   - After line 0 it reads 8'b01_10_11_00.
   - After 4 lines it returns to 8'b00_01_10_11.
4. frame_start asserted at pixel 20 of frame 1.
   - Counters restart and that pixel is written at buffer 0, address 0.
   - Then 8 filt_en pulses over 48 further pixels.
5. pix_valid pulses with no prior frame_start.
   - No lb_wr_en and drop_err=1.
   - A subsequent frame_start clears drop_err.
6. rst asserted mid-frame, while out_valid is in flight.
   - All outputs are 0 on the next cycle and state is IDLE.
   - Pixels after reset raise drop_err.

Source files
------------

// File: rtl/filter_win_ctrl_if.sv
// Handshake bundle between the camera-side pixel stream and the 5x5 window
// sequencer.
//   master : drives frame_start / pix_valid and observes the control outputs
//   slave  : the sequencer; it consumes the pixel strobes and drives the
//            line-buffer controls, the filter enable and the output strobe
// Signals:
//   frame_start, pix_valid      pixel stream framing
//   lb_addr, lb_wr_en, row_map  line-buffer address, write select, row rotation
//   filt_en                     filter enable
//   out_valid, out_x, out_y     delayed valid with window-centre coordinates
//   frame_done, drop_err        end-of-frame pulse, sticky dropped-pixel flag
interface filter_win_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              frame_start;
  logic              pix_valid;
  logic [ADDR_W-1:0] lb_addr;
  logic [3:0]        lb_wr_en;
  logic [7:0]        row_map;
  logic              filt_en;
  logic              out_valid;
  logic [ADDR_W-1:0] out_x;
  logic [ADDR_W-1:0] out_y;
  logic              frame_done;
  logic              drop_err;

  modport master (
    output frame_start, pix_valid,
    input  lb_addr, lb_wr_en, row_map, filt_en, out_valid, out_x, out_y,
           frame_done, drop_err
  );

  modport slave (
    input  frame_start, pix_valid,
    output lb_addr, lb_wr_en, row_map, filt_en, out_valid, out_x, out_y,
           frame_done, drop_err
  );
endinterface

// File: rtl/filter_win_ctrl.sv
// Sequencer for the 5x5 binary Gaussian window filter. It tracks the pixel
// column/row inside a frame, drives address, write-select and row rotation
// for four external read-first 1-bit line buffers, raises filt_en when a full
// 5x5 neighbourhood is present, and emits out_valid with the window-centre
// coordinates FILT_LAT cycles after filt_en.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  filter_win_ctrl_if.slave (frame_start, pix_valid in; all else out)
module filter_win_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ADDR_W   = 10,
  parameter int FILT_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  filter_win_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] WIN_MIN  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] CTR_OFS  = ADDR_W'(2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] col_q, row_q;
  logic [1:0]        ptr_q;
  logic              frame_done_q, drop_err_q;

  logic              active, restart, accept, eol, last, win;
  logic [ADDR_W-1:0] col_eff, row_eff;
  logic [1:0]        ptr_eff;

  logic              vld_p0;
  logic [ADDR_W-1:0] x_p0, y_p0;
  logic              vld_pn [FILT_LAT];
  logic [ADDR_W-1:0] x_pn   [FILT_LAT];
  logic [ADDR_W-1:0] y_pn   [FILT_LAT];

  assign active  = (state_q == S_ACTIVE);
  // A frame_start during ACTIVE makes the coincident pixel pixel (0,0), so the
  // counters are bypassed to zero combinationally for that cycle.
  assign restart = active && bus.frame_start;
  assign col_eff = restart ? '0 : col_q;
  assign row_eff = restart ? '0 : row_q;
  assign ptr_eff = restart ? 2'd0 : ptr_q;

  assign accept  = active && bus.pix_valid;
  assign eol     = (col_eff == COL_LAST);
  assign last    = eol && (row_eff == ROW_LAST);
  assign win     = accept && (row_eff >= WIN_MIN) && (col_eff >= WIN_MIN);

  assign bus.lb_addr    = col_eff;
  assign bus.lb_wr_en   = accept ? (4'b0001 << ptr_eff) : 4'b0000;
  // Oldest row (r-4) sits in the buffer about to be overwritten; r-1 is the
  // buffer written on the previous line.
  assign bus.row_map    = {ptr_q, ptr_q + 2'd1, ptr_q + 2'd2, ptr_q + 2'd3};
  assign bus.filt_en    = vld_p0;
  assign bus.out_valid  = vld_pn[FILT_LAT-1];
  assign bus.out_x      = x_pn[FILT_LAT-1];
  assign bus.out_y      = y_pn[FILT_LAT-1];
  assign bus.frame_done = frame_done_q;
  assign bus.drop_err   = drop_err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.frame_start) state_d = S_ACTIVE;
      S_ACTIVE: if (accept && last) state_d = S_DONE;
      S_DONE:   state_d = bus.frame_start ? S_ACTIVE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_done_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= accept && last;
      // A pixel dropped in the same cycle as frame_start still flags, so the
      // loss is never masked by the clear.
      if (bus.pix_valid && !active) drop_err_q <= 1'b1;
      else if (bus.frame_start)     drop_err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      ptr_q <= 2'd0;
    end else if (bus.frame_start && !active) begin
      col_q <= '0;
      row_q <= '0;
      ptr_q <= 2'd0;
    end else if (accept) begin
      if (eol) begin
        col_q <= '0;
        row_q <= last ? '0 : row_eff + 1'b1;
        ptr_q <= ptr_eff + 2'd1;
      end else begin
        col_q <= col_eff + 1'b1;
        row_q <= row_eff;
        ptr_q <= ptr_eff;
      end
    end else if (restart) begin
      col_q <= '0;
      row_q <= '0;
      ptr_q <= 2'd0;
    end
  end

  // Stage p0: filter enable, aligned with read-first RAM output
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      x_p0   <= '0;
      y_p0   <= '0;
    end else begin
      vld_p0 <= win;
      if (win) begin
        x_p0 <= col_eff - CTR_OFS;
        y_p0 <= row_eff - CTR_OFS;
      end
    end
  end

  // Stages p1..pFILT_LAT: match filter latency; only rst flushes windows in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FILT_LAT; i++) begin
        vld_pn[i] <= 1'b0;
        x_pn[i]   <= '0;
        y_pn[i]   <= '0;
      end
    end else begin
      vld_pn[0] <= vld_p0;
      x_pn[0]   <= x_p0;
      y_pn[0]   <= y_p0;
      for (int i = 1; i < FILT_LAT; i++) begin
        vld_pn[i] <= vld_pn[i-1];
        x_pn[i]   <= x_pn[i-1];
        y_pn[i]   <= y_pn[i-1];
      end
    end
  end

endmodule

// File: tb/tb_filter_win_ctrl.sv
// Directed bench for filter_win_ctrl on an 8x6 frame with FILT_LAT=2.
module tb_filter_win_ctrl;
  localparam int W   = 8;
  localparam int H   = 6;
  localparam int AW  = 10;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;

  filter_win_ctrl_if #(.ADDR_W(AW)) bus_if ();

  filter_win_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FILT_LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  int   cyc = 0;
  int   n_filt, first_filt, n_ov, first_ov, ov_x, ov_y, n_done, done_cyc;
  int   wr_err, filt_err, rm_line1, rm_line4;
  int   pix_cyc [0:W*H-1];
  logic exp_filt;

  task automatic clear_stats();
    n_filt = 0; first_filt = -1; n_ov = 0; first_ov = -1; ov_x = -1; ov_y = -1;
    n_done = 0; done_cyc = -1; wr_err = 0; filt_err = 0;
    rm_line1 = -1; rm_line4 = -1;
  endtask

  // One clock cycle: drive inputs, then sample. Registered outputs seen here
  // reflect the inputs of the previous cycle. idx >= 0 marks an in-frame pixel.
  task automatic tick(input logic r, input logic fs, input logic pv, input int idx);
    @(posedge clk);
    #2;
    rst = r;
    bus_if.frame_start = fs;
    bus_if.pix_valid   = pv;
    #1;
    cyc++;
    if (bus_if.filt_en !== exp_filt) filt_err++;
    if (bus_if.filt_en) begin
      if (first_filt < 0) first_filt = cyc;
      n_filt++;
    end
    if (bus_if.out_valid) begin
      if (first_ov < 0) begin
        first_ov = cyc;
        ov_x = int'(bus_if.out_x);
        ov_y = int'(bus_if.out_y);
      end
      n_ov++;
    end
    if (bus_if.frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (pv && idx >= 0) begin
      pix_cyc[idx] = cyc;
      if (bus_if.lb_addr !== AW'(idx % W) ||
          bus_if.lb_wr_en !== 4'(1 << ((idx / W) % 4))) wr_err++;
      if (idx == W)     rm_line1 = int'(bus_if.row_map);
      if (idx == 4 * W) rm_line4 = int'(bus_if.row_map);
    end else if (bus_if.lb_wr_en !== 4'b0000) begin
      wr_err++;
    end
    exp_filt = !r && pv && idx >= 0 && (idx / W) >= 4 && (idx % W) >= 4;
  endtask

  task automatic run_frame(input bit gap);
    tick(1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < W * H; i++) begin
      tick(1'b0, 1'b0, 1'b1, i);
      if (gap) tick(1'b0, 1'b0, 1'b0, -1);
    end
    repeat (4) tick(1'b0, 1'b0, 1'b0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.frame_start = 1'b0;
    bus_if.pix_valid   = 1'b0;
    exp_filt = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    tick(1'b1, 1'b0, 1'b0, -1);
    tick(1'b0, 1'b0, 1'b0, -1);

    // Reset state
    chk("rst_filt_en",    int'(bus_if.filt_en), 0);
    chk("rst_out_valid",  int'(bus_if.out_valid), 0);
    chk("rst_frame_done", int'(bus_if.frame_done), 0);
    chk("rst_drop_err",   int'(bus_if.drop_err), 0);
    chk("rst_out_xy",     int'(bus_if.out_x) + int'(bus_if.out_y), 0);
    chk("rst_lb_wr_en",   int'(bus_if.lb_wr_en), 0);
    chk("rst_lb_addr",    int'(bus_if.lb_addr), 0);
    chk("rst_row_map",    int'(bus_if.row_map), 8'b00_01_10_11);

    // Back-to-back frame
    clear_stats();
    run_frame(1'b0);
    chk("f1_filt_count",    n_filt, 8);
    chk("f1_first_filt",    first_filt - pix_cyc[36], 1);
    chk("f1_ov_latency",    first_ov - first_filt, 2);
    chk("f1_first_x",       ov_x, 2);
    chk("f1_first_y",       ov_y, 2);
    chk("f1_ov_count",      n_ov, 8);
    chk("f1_done_time",     done_cyc - pix_cyc[47], 1);
    chk("f1_done_count",    n_done, 1);
    chk("f1_wr_errs",       wr_err, 0);
    chk("f1_filt_errs",     filt_err, 0);
    chk("f1_row_map_line1", rm_line1, 8'b01_10_11_00);
    chk("f1_row_map_line4", rm_line4, 8'b00_01_10_11);

    // Same frame with pix_valid every other cycle
    clear_stats();
    run_frame(1'b1);
    chk("f2_filt_count", n_filt, 8);
    chk("f2_filt_errs",  filt_err, 0);
    chk("f2_wr_errs",    wr_err, 0);
    chk("f2_ov_count",   n_ov, 8);
    chk("f2_done_time",  done_cyc - pix_cyc[47], 1);
    chk("f2_drop_err",   int'(bus_if.drop_err), 0);

    // Restart at pixel 20
    clear_stats();
    tick(1'b0, 1'b1, 1'b0, -1);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, i);
    tick(1'b0, 1'b1, 1'b1, 0);
    chk("rs_addr",  int'(bus_if.lb_addr), 0);
    chk("rs_wr_en", int'(bus_if.lb_wr_en), 1);
    for (int i = 1; i < W * H; i++) tick(1'b0, 1'b0, 1'b1, i);
    repeat (4) tick(1'b0, 1'b0, 1'b0, -1);
    chk("rs_filt_count", n_filt, 8);
    chk("rs_done_time",  done_cyc - pix_cyc[47], 1);
    chk("rs_done_count", n_done, 1);
    chk("rs_wr_errs",    wr_err, 0);
    chk("rs_filt_errs",  filt_err, 0);

    // Pixels with no frame in progress
    clear_stats();
    repeat (3) tick(1'b0, 1'b0, 1'b1, -1);
    tick(1'b0, 1'b0, 1'b0, -1);
    chk("idle_wr_errs",  wr_err, 0);
    chk("idle_no_filt",  n_filt, 0);
    chk("idle_drop_set", int'(bus_if.drop_err), 1);
    tick(1'b0, 1'b1, 1'b0, -1);
    tick(1'b0, 1'b0, 1'b0, -1);
    chk("drop_cleared",  int'(bus_if.drop_err), 0);

    // Reset mid-frame with windows in flight
    for (int i = 0; i < 39; i++) tick(1'b0, 1'b0, 1'b1, i);
    chk("mid_filt_seen", int'(bus_if.filt_en), 1);
    tick(1'b1, 1'b0, 1'b0, -1);
    tick(1'b0, 1'b0, 1'b0, -1);
    chk("mr_filt_en",    int'(bus_if.filt_en), 0);
    chk("mr_out_valid",  int'(bus_if.out_valid), 0);
    chk("mr_out_xy",     int'(bus_if.out_x) + int'(bus_if.out_y), 0);
    chk("mr_frame_done", int'(bus_if.frame_done), 0);
    chk("mr_drop_err",   int'(bus_if.drop_err), 0);
    chk("mr_lb_addr",    int'(bus_if.lb_addr), 0);
    chk("mr_row_map",    int'(bus_if.row_map), 8'b00_01_10_11);
    clear_stats();
    repeat (2) tick(1'b0, 1'b0, 1'b1, -1);
    repeat (3) tick(1'b0, 1'b0, 1'b0, -1);
    chk("mr_wr_errs",  wr_err, 0);
    chk("mr_no_ov",    n_ov, 0);
    chk("mr_no_filt",  n_filt, 0);
    chk("mr_drop_set", int'(bus_if.drop_err), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
